// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the boot-time RAM loader.
package ram_loader_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;

  // A length header of zero requests a full 2**ADDR_W byte image.
  localparam bit LEN_ZERO_MEANS_FULL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CSUM,
    FIN
  } loader_state_t;

endpackage

// File: rtl/ram_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream and writes
// the payload into the 8-bit RAM, holding the CPU off the bus until done.
// Optional trailing checksum byte enabled by defining RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
  parameter int unsigned DATA_W    = ram_loader_pkg::DATA_W,
  parameter int unsigned ADDR_W    = ram_loader_pkg::ADDR_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wm,
  output logic              ram_wb,
  output logic              bus_oe,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);
  import ram_loader_pkg::*;

  // Count and pointer carry one extra bit so a full-depth image fits.
  localparam int unsigned CW = ADDR_W + 1;

  loader_state_t     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;
  logic              done_d;
  logic              hold_d;
  logic              error_d;
  logic              hs;

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign hs     = in_valid & in_ready;
  // The loader only ever writes RAM; it never asks RAM to drive the bus.
  assign ram_wb = 1'b0;

  // Next-state and next-register-value logic for the load sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = ram_addr;
    data_d  = ram_data;
    done_d  = done;
    hold_d  = cpu_hold;
    error_d = error;
`ifdef RAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR;
          done_d  = 1'b0;
          error_d = 1'b0;
          hold_d  = 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      HDR: begin
        if (hs) begin
          if (LEN_ZERO_MEANS_FULL && in_data == '0) cnt_d = CW'(1) << ADDR_W;
          else                                      cnt_d = CW'(in_data);
          ptr_d   = '0;
          state_d = DATA;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
        end
      end
      DATA: begin
        if (hs) begin
          data_d  = in_data;
          addr_d  = ADDR_W'(CW'(BASE_ADDR) + ptr_q);
          state_d = WRITE;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
        end
      end
      WRITE: begin
        ptr_d = ptr_q + CW'(1);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef RAM_LOADER_CHECKSUM_EN
          state_d = CSUM;
`else
          state_d = FIN;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (hs) begin
          // The trailing byte makes the whole stream sum to zero when intact.
          if (DATA_W'(sum_q + in_data) == '0) begin
            state_d = FIN;
          end else begin
            state_d = IDLE;
            error_d = 1'b1;
          end
        end
      end
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Releasing the CPU happens only on a successful finish.
    if (state_d == FIN) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
  end

  // State, counters and registered outputs; outputs follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      in_ready <= 1'b0;
      ram_addr <= ADDR_W'(BASE_ADDR);
      ram_data <= '0;
      ram_wm   <= 1'b0;
      bus_oe   <= 1'b0;
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      in_ready <= (state_d == HDR) || (state_d == DATA) || (state_d == CSUM);
      ram_addr <= addr_d;
      ram_data <= data_d;
      ram_wm   <= (state_d == WRITE);
      bus_oe   <= (state_d == WRITE);
      cpu_hold <= hold_d;
      busy     <= (state_d == HDR) || (state_d == DATA) ||
                  (state_d == WRITE) || (state_d == CSUM);
      done     <= done_d;
    end
  end

`ifdef RAM_LOADER_CHECKSUM_EN
  // Running checksum and sticky failure flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      error <= 1'b0;
    end else begin
      sum_q <= sum_d;
      error <= error_d;
    end
  end
`else
  assign error = 1'b0;
  logic unused_error_d;
  assign unused_error_d = error_d;
`endif

endmodule
